h_serial_adder: RTL

Bit-serial WIDTH-bit adder that accepts two operands over a valid/ready handshake and adds them LSB-first, one bit per clock. It holds the running carry in a single flip-flop. Each bit slice is a full adder built from two half-adder cells. It sits downstream of the operand source and upstream of any consumer, such as a register file or accumulator, that accepts its sum/carry result over a second valid/ready handshake.

---
 rtl/h_serial_adder_pkg.sv | 22 ++
 rtl/h_serial_adder_fa.sv | 48 ++++
 rtl/h_serial_adder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/h_serial_adder_pkg.sv
// h_serial_adder_pkg: shared definitions for the bit-serial adder.
// Holds the controller state encodings and the default operand width so the
// top level, its sub-module and any bench agree on them.
package h_serial_adder_pkg;

  // Default operand / sum width in bits (legal range is 2 and up).
  localparam int H_SERIAL_DEFAULT_WIDTH = 16;

  // Controller states: IDLE accepts operands, RUN adds one bit per clock,
  // DONE presents the result until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width for a given operand width; never below one bit.
  function automatic int cntWidth(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/h_serial_adder_fa.sv
// h_serial_adder_fa: one bit slice of the serial adder.
// hHalfAdder is the basic cell; hFullAdder chains two of them and ORs their
// carries, which is the classic two-half-adder full adder.

module hHalfAdder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

module hFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic partialSum;
  logic carryAb;
  logic carryCin;

  // First cell combines the operand bits.
  hHalfAdder u_haAb (
    .a    (a),
    .b    (b),
    .sum  (partialSum),
    .cout (carryAb)
  );

  // Second cell folds in the incoming carry.
  hHalfAdder u_haCin (
    .a    (partialSum),
    .b    (cin),
    .sum  (sum),
    .cout (carryCin)
  );

  // At most one of the two cells can generate a carry, so OR is exact.
  assign cout = carryAb | carryCin;

endmodule

// File: rtl/h_serial_adder.sv
// h_serial_adder: bit-serial WIDTH-bit adder with valid/ready handshakes on
// both the operand side and the result side. Adds LSB-first, one bit per
// clock, keeping the running carry in a single flip-flop.
// Optional feature macro: H_SERIAL_ADDER_SUB_EN adds the 'sub' port, which
// inverts b on load and seeds the carry with 1 to form a - b.

module h_serial_adder
  import h_serial_adder_pkg::*;
#(
  parameter int WIDTH = H_SERIAL_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef H_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic             carry_q;
  logic             carry_out_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] a_sr_d;
  logic [WIDTH-1:0] b_sr_d;
  logic [WIDTH-1:0] sum_sr_d;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] b_load_d;
  logic             carry_seed_d;
  logic             slice_sum;
  logic             slice_cout;

  // Operand B and the carry seed as loaded at acceptance; subtraction is
  // a + ~b + 1, so the +1 rides in on the initial carry.
`ifdef H_SERIAL_ADDER_SUB_EN
  assign b_load_d     = sub ? ~b : b;
  assign carry_seed_d = sub;
`else
  assign b_load_d     = b;
  assign carry_seed_d = 1'b0;
`endif

  // The single bit slice always works on the current LSBs and running carry.
  hFullAdder u_slice (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Shifted register contents for one RUN step: operands move right, the new
  // sum bit enters at the MSB so after WIDTH steps the sum is in place.
  assign a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
  assign b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
  assign sum_sr_d = {slice_sum, sum_sr_q[WIDTH-1:1]};
  assign cnt_d    = cnt_q + CNT_W'(1);

  // Controller and datapath registers; handshake outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sr_q     <= a;
            b_sr_q     <= b_load_d;
            carry_q    <= carry_seed_d;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          a_sr_q   <= a_sr_d;
          b_sr_q   <= b_sr_d;
          sum_sr_q <= sum_sr_d;
          carry_q  <= slice_cout;
          cnt_q    <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            carry_out_q <= slice_cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_sr_q;
  assign carry_out = carry_out_q;

endmodule
